// File: rtl/alu_share_arbiter.sv
// Shared ALU front-end: two valid/ready requesters, a round-robin grant, and one
// registered response slot tagged with the owning requester id.

// Combinational ALU shared by both requesters.
module alu #(
  parameter int DATA_WIDTH    = 32,
  parameter int OPCODE_LENGTH = 4
) (
  input  logic [DATA_WIDTH-1:0]    SrcA,
  input  logic [DATA_WIDTH-1:0]    SrcB,
  input  logic [OPCODE_LENGTH-1:0] Operation,
  output logic [DATA_WIDTH-1:0]    ALUResult
);

  localparam int SHW = $clog2(DATA_WIDTH);

  localparam logic [OPCODE_LENGTH-1:0] OP_AND = OPCODE_LENGTH'(0);
  localparam logic [OPCODE_LENGTH-1:0] OP_OR  = OPCODE_LENGTH'(1);
  localparam logic [OPCODE_LENGTH-1:0] OP_ADD = OPCODE_LENGTH'(2);
  localparam logic [OPCODE_LENGTH-1:0] OP_XOR = OPCODE_LENGTH'(3);
  localparam logic [OPCODE_LENGTH-1:0] OP_SLL = OPCODE_LENGTH'(4);
  localparam logic [OPCODE_LENGTH-1:0] OP_SRL = OPCODE_LENGTH'(5);
  localparam logic [OPCODE_LENGTH-1:0] OP_SUB = OPCODE_LENGTH'(6);
  localparam logic [OPCODE_LENGTH-1:0] OP_SRA = OPCODE_LENGTH'(7);
  localparam logic [OPCODE_LENGTH-1:0] OP_EQ  = OPCODE_LENGTH'(8);
  localparam logic [OPCODE_LENGTH-1:0] OP_GE  = OPCODE_LENGTH'(9);
  localparam logic [OPCODE_LENGTH-1:0] OP_NE  = OPCODE_LENGTH'(10);
  localparam logic [OPCODE_LENGTH-1:0] OP_SLT = OPCODE_LENGTH'(12);

  logic [SHW-1:0] shamt;
  assign shamt = SrcB[SHW-1:0];

  // Operation decode; undefined opcodes produce zero.
  always_comb begin
    ALUResult = '0;
    case (Operation)
      OP_AND:  ALUResult = SrcA & SrcB;
      OP_OR:   ALUResult = SrcA | SrcB;
      OP_ADD:  ALUResult = SrcA + SrcB;
      OP_XOR:  ALUResult = SrcA ^ SrcB;
      OP_SLL:  ALUResult = SrcA << shamt;
      OP_SRL:  ALUResult = SrcA >> shamt;
      OP_SUB:  ALUResult = SrcA - SrcB;
      OP_SRA:  ALUResult = $unsigned($signed(SrcA) >>> shamt);
      OP_EQ:   ALUResult = DATA_WIDTH'(SrcA == SrcB);
      OP_GE:   ALUResult = DATA_WIDTH'($signed(SrcA) >= $signed(SrcB));
      OP_NE:   ALUResult = DATA_WIDTH'(SrcA != SrcB);
      OP_SLT:  ALUResult = DATA_WIDTH'($signed(SrcA) < $signed(SrcB));
      default: ALUResult = '0;
    endcase
  end

endmodule

module alu_share_arbiter #(
  parameter int DATA_WIDTH    = 32,
  parameter int OPCODE_LENGTH = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     req0_valid,
  output logic                     req0_ready,
  input  logic [DATA_WIDTH-1:0]    req0_a,
  input  logic [DATA_WIDTH-1:0]    req0_b,
  input  logic [OPCODE_LENGTH-1:0] req0_op,
  input  logic                     req1_valid,
  output logic                     req1_ready,
  input  logic [DATA_WIDTH-1:0]    req1_a,
  input  logic [DATA_WIDTH-1:0]    req1_b,
  input  logic [OPCODE_LENGTH-1:0] req1_op,
  output logic                     rsp_valid,
  input  logic                     rsp_ready,
  output logic                     rsp_id,
  output logic [DATA_WIDTH-1:0]    rsp_result
);

  typedef enum logic {EMPTY, FULL} state_t;

  state_t                  state_q, state_d;
  logic                    rsp_id_q, rsp_id_d;
  logic [DATA_WIDTH-1:0]   rsp_result_q, rsp_result_d;
  logic                    last_grant_q, last_grant_d;

  logic                     grant_valid;
  logic                     grant_id;
  logic                     can_accept;
  logic                     fire;
  logic [DATA_WIDTH-1:0]    alu_a, alu_b, alu_y;
  logic [OPCODE_LENGTH-1:0] alu_op;

  // Round-robin grant: contention goes to the requester not served last.
  always_comb begin
    grant_valid = req0_valid | req1_valid;
    grant_id    = 1'b0;
    if (req0_valid && req1_valid) grant_id = ~last_grant_q;
    else if (req1_valid)          grant_id = 1'b1;
    can_accept = (state_q == EMPTY) | rsp_ready;
    fire       = can_accept & grant_valid;
    req0_ready = fire & ~grant_id;
    req1_ready = fire & grant_id;
    alu_a      = grant_id ? req1_a  : req0_a;
    alu_b      = grant_id ? req1_b  : req0_b;
    alu_op     = grant_id ? req1_op : req0_op;
  end

  alu #(
    .DATA_WIDTH   (DATA_WIDTH),
    .OPCODE_LENGTH(OPCODE_LENGTH)
  ) u_alu (
    .SrcA     (alu_a),
    .SrcB     (alu_b),
    .Operation(alu_op),
    .ALUResult(alu_y)
  );

  // Response slot next-state: load on fire, empty on drain without refill.
  always_comb begin
    state_d      = state_q;
    rsp_id_d     = rsp_id_q;
    rsp_result_d = rsp_result_q;
    last_grant_d = last_grant_q;
    if (fire) begin
      state_d      = FULL;
      rsp_id_d     = grant_id;
      rsp_result_d = alu_y;
      last_grant_d = grant_id;
    end else if (state_q == FULL && rsp_ready) begin
      state_d = EMPTY;
    end
  end

  // State and response registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= EMPTY;
      rsp_id_q     <= 1'b0;
      rsp_result_q <= '0;
      last_grant_q <= 1'b1;
    end else begin
      state_q      <= state_d;
      rsp_id_q     <= rsp_id_d;
      rsp_result_q <= rsp_result_d;
      last_grant_q <= last_grant_d;
    end
  end

  assign rsp_valid  = (state_q == FULL);
  assign rsp_id     = rsp_id_q;
  assign rsp_result = rsp_result_q;

endmodule

// File: tb/tb_alu_share_arbiter.sv
// Bench for alu_share_arbiter: directed scenarios plus a randomized run checked
// against a rule-level reference of the arbiter and ALU.
module tb_alu_share_arbiter;

  localparam int DW = 32;
  localparam int OW = 4;

  logic          clk = 1'b0;
  logic          reset;
  logic          req0_valid, req0_ready, req1_valid, req1_ready;
  logic [DW-1:0] req0_a, req0_b, req1_a, req1_b;
  logic [OW-1:0] req0_op, req1_op;
  logic          rsp_valid, rsp_ready, rsp_id;
  logic [DW-1:0] rsp_result;

  int n_cmp = 0;
  int n_err = 0;

  alu_share_arbiter #(.DATA_WIDTH(DW), .OPCODE_LENGTH(OW)) dut (
    .clk(clk), .reset(reset),
    .req0_valid(req0_valid), .req0_ready(req0_ready),
    .req0_a(req0_a), .req0_b(req0_b), .req0_op(req0_op),
    .req1_valid(req1_valid), .req1_ready(req1_ready),
    .req1_a(req1_a), .req1_b(req1_b), .req1_op(req1_op),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_id(rsp_id), .rsp_result(rsp_result)
  );

  always #5 clk = ~clk;

  // Reference arithmetic written from the opcode table.
  function automatic logic [31:0] alu_ref(input logic [31:0] a, input logic [31:0] b,
                                          input logic [3:0] op);
    logic [4:0] s;
    logic       lt;
    s  = b[4:0];
    lt = (a ^ 32'h8000_0000) < (b ^ 32'h8000_0000);
    case (op)
      4'd0:    return a & b;
      4'd1:    return a | b;
      4'd2:    return a + b;
      4'd3:    return a ^ b;
      4'd4:    return a << s;
      4'd5:    return a >> s;
      4'd6:    return a - b;
      4'd7:    return (a >> s) | (a[31] ? ~(32'hFFFF_FFFF >> s) : 32'h0);
      4'd8:    return {31'd0, a == b};
      4'd9:    return {31'd0, !lt};
      4'd10:   return {31'd0, a != b};
      4'd12:   return {31'd0, lt};
      default: return 32'd0;
    endcase
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    req0_valid = 1'b0; req1_valid = 1'b0;
    req0_a = '0; req0_b = '0; req0_op = '0;
    req1_a = '0; req1_b = '0; req1_op = '0;
  endtask

  task automatic do_reset();
    idle_inputs();
    reset = 1'b1;
    #2;
    reset = 1'b0;
  endtask

  task automatic test_reset();
    idle_inputs();
    rsp_ready = 1'b0;
    reset = 1'b1;
    tick();
    n_cmp++;
    if (rsp_valid !== 1'b0 || rsp_id !== 1'b0 || rsp_result !== 32'd0) begin
      n_err++;
      $display("FAIL reset_state: valid=%b id=%b result=%h, required 0 0 00000000",
               rsp_valid, rsp_id, rsp_result);
    end
    reset = 1'b0;
    tick();
  endtask

  task automatic test_single_add();
    do_reset();
    rsp_ready = 1'b1;
    req0_valid = 1'b1; req0_a = 32'd5; req0_b = 32'd7; req0_op = 4'd2;
    #1;
    n_cmp++;
    if (req0_ready !== 1'b1 || req1_ready !== 1'b0) begin
      n_err++;
      $display("FAIL add_ready: r0=%b r1=%b, required 1 0", req0_ready, req1_ready);
    end
    tick();
    req0_valid = 1'b0;
    n_cmp++;
    if (rsp_valid !== 1'b1 || rsp_id !== 1'b0 || rsp_result !== 32'd12) begin
      n_err++;
      $display("FAIL add_rsp: valid=%b id=%b result=%0d, required 1 0 12",
               rsp_valid, rsp_id, rsp_result);
    end
    tick();
    n_cmp++;
    if (rsp_valid !== 1'b0) begin
      n_err++;
      $display("FAIL add_drain: valid=%b, required 0", rsp_valid);
    end
  endtask

  task automatic test_alternate();
    logic [31:0] exp_res;
    do_reset();
    rsp_ready = 1'b1;
    req0_valid = 1'b1; req0_a = 32'd10; req0_b = 32'd3; req0_op = 4'd6;
    req1_valid = 1'b1; req1_a = 32'hF0; req1_b = 32'h0F; req1_op = 4'd3;
    for (int i = 0; i < 8; i++) begin
      #1;
      n_cmp++;
      if (req0_ready !== (i % 2 == 0) || req1_ready !== (i % 2 == 1)) begin
        n_err++;
        $display("FAIL alt_ready[%0d]: r0=%b r1=%b, required %b %b",
                 i, req0_ready, req1_ready, i % 2 == 0, i % 2 == 1);
      end
      tick();
      exp_res = (i % 2 == 0) ? 32'd7 : 32'hFF;
      n_cmp++;
      if (rsp_valid !== 1'b1 || rsp_id !== 1'(i % 2) || rsp_result !== exp_res) begin
        n_err++;
        $display("FAIL alt_rsp[%0d]: valid=%b id=%b result=%h, required 1 %0d %h",
                 i, rsp_valid, rsp_id, rsp_result, i % 2, exp_res);
      end
    end
    idle_inputs();
    tick();
  endtask

  task automatic test_backpressure();
    do_reset();
    rsp_ready = 1'b0;
    req1_valid = 1'b1; req1_a = 32'hFFFF_FFFF; req1_b = 32'd1; req1_op = 4'd2;
    tick();
    req0_valid = 1'b1; req0_a = 32'd1; req0_b = 32'd2; req0_op = 4'd1;
    req1_a = 32'd9; req1_b = 32'd9; req1_op = 4'd2;
    for (int i = 0; i < 3; i++) begin
      #1;
      n_cmp++;
      if (rsp_valid !== 1'b1 || rsp_id !== 1'b1 || rsp_result !== 32'd0 ||
          req0_ready !== 1'b0 || req1_ready !== 1'b0) begin
        n_err++;
        $display("FAIL stall[%0d]: valid=%b id=%b result=%h r0=%b r1=%b, required 1 1 00000000 0 0",
                 i, rsp_valid, rsp_id, rsp_result, req0_ready, req1_ready);
      end
      tick();
    end
    idle_inputs();
    rsp_ready = 1'b1;
    tick();
    n_cmp++;
    if (rsp_valid !== 1'b0) begin
      n_err++;
      $display("FAIL stall_drain: valid=%b, required 0", rsp_valid);
    end
  endtask

  task automatic test_opcodes();
    logic [31:0] a, b, exp_res;
    logic [3:0]  op;
    do_reset();
    rsp_ready = 1'b1;
    for (int i = 0; i < 40; i++) begin
      case (i)
        0: begin a = 32'd1;          b = 32'd1; op = 4'hF; end
        1: begin a = 32'hFFFF_FFFF;  b = 32'd1; op = 4'hC; end
        2: begin a = 32'h8000_0000;  b = 32'd4; op = 4'h7; end
        default: begin
          a  = (i % 3 == 0) ? 32'($urandom_range(0, 8)) : $urandom;
          b  = (i % 4 == 0) ? a : $urandom;
          op = 4'(i % 16);
        end
      endcase
      exp_res = (i == 0) ? 32'd0 : (i == 1) ? 32'd1 : (i == 2) ? 32'hF800_0000
              : alu_ref(a, b, op);
      req0_valid = 1'b1; req0_a = a; req0_b = b; req0_op = op;
      tick();
      n_cmp++;
      if (rsp_valid !== 1'b1 || rsp_result !== exp_res) begin
        n_err++;
        $display("FAIL opcode[%0d] op=%h a=%h b=%h: valid=%b result=%h, required 1 %h",
                 i, op, a, b, rsp_valid, rsp_result, exp_res);
      end
    end
    idle_inputs();
    tick();
  endtask

  task automatic test_reset_midflight();
    do_reset();
    rsp_ready = 1'b0;
    req0_valid = 1'b1; req0_a = 32'd3; req0_b = 32'd4; req0_op = 4'd2;
    req1_valid = 1'b1; req1_a = 32'd8; req1_b = 32'd1; req1_op = 4'd6;
    tick();
    tick();
    #2;
    reset = 1'b1;
    #1;
    n_cmp++;
    if (rsp_valid !== 1'b0 || rsp_id !== 1'b0 || rsp_result !== 32'd0) begin
      n_err++;
      $display("FAIL midreset: valid=%b id=%b result=%h, required 0 0 00000000",
               rsp_valid, rsp_id, rsp_result);
    end
    #2;
    reset = 1'b0;
    rsp_ready = 1'b1;
    #1;
    n_cmp++;
    if (req0_ready !== 1'b1 || req1_ready !== 1'b0) begin
      n_err++;
      $display("FAIL midreset_grant: r0=%b r1=%b, required 1 0", req0_ready, req1_ready);
    end
    tick();
    n_cmp++;
    if (rsp_valid !== 1'b1 || rsp_id !== 1'b0 || rsp_result !== 32'd7) begin
      n_err++;
      $display("FAIL midreset_rsp: valid=%b id=%b result=%h, required 1 0 00000007",
               rsp_valid, rsp_id, rsp_result);
    end
    idle_inputs();
    tick();
  endtask

  task automatic test_stream();
    logic [31:0] q[$];
    logic [31:0] a, b, exp_res;
    do_reset();
    rsp_ready = 1'b1;
    for (int i = 0; i < 9; i++) begin
      if (i < 8) begin
        a = $urandom; b = $urandom;
        req0_valid = 1'b1; req0_a = a; req0_b = b; req0_op = 4'd2;
        q.push_back(a + b);
      end else begin
        req0_valid = 1'b0;
      end
      tick();
      if (i < 8) begin
        exp_res = q.pop_front();
        n_cmp++;
        if (rsp_valid !== 1'b1 || rsp_id !== 1'b0 || rsp_result !== exp_res) begin
          n_err++;
          $display("FAIL stream[%0d]: valid=%b id=%b result=%h, required 1 0 %h",
                   i, rsp_valid, rsp_id, rsp_result, exp_res);
        end
      end else begin
        n_cmp++;
        if (rsp_valid !== 1'b0) begin
          n_err++;
          $display("FAIL stream_end: valid=%b, required 0", rsp_valid);
        end
      end
    end
  endtask

  // Randomized traffic; requesters hold a pending request until it is accepted.
  task automatic test_random();
    logic        p[2];
    logic [31:0] ra[2], rb[2];
    logic [3:0]  rop[2];
    logic        m_full, m_id, m_last, can, has, g, e0, e1;
    logic [31:0] m_res;
    do_reset();
    p[0] = 1'b0; p[1] = 1'b0;
    m_full = 1'b0; m_id = 1'b0; m_res = '0; m_last = 1'b1;
    for (int c = 0; c < 400; c++) begin
      n_cmp++;
      if (rsp_valid !== m_full || (m_full && (rsp_id !== m_id || rsp_result !== m_res))) begin
        n_err++;
        $display("FAIL rand_rsp[%0d]: valid=%b id=%b result=%h, required %b %b %h",
                 c, rsp_valid, rsp_id, rsp_result, m_full, m_id, m_res);
      end
      for (int r = 0; r < 2; r++) begin
        if (!p[r] && $urandom_range(0, 9) < 6) begin
          p[r] = 1'b1; ra[r] = $urandom; rb[r] = $urandom; rop[r] = 4'($urandom_range(0, 15));
        end
      end
      req0_valid = p[0]; req0_a = ra[0]; req0_b = rb[0]; req0_op = rop[0];
      req1_valid = p[1]; req1_a = ra[1]; req1_b = rb[1]; req1_op = rop[1];
      rsp_ready  = ($urandom_range(0, 3) != 0);
      #1;
      can = !m_full || rsp_ready;
      has = p[0] || p[1];
      g   = (p[0] && p[1]) ? !m_last : p[1];
      e0  = can && has && !g;
      e1  = can && has && g;
      n_cmp++;
      if (req0_ready !== e0 || req1_ready !== e1) begin
        n_err++;
        $display("FAIL rand_ready[%0d]: r0=%b r1=%b, required %b %b",
                 c, req0_ready, req1_ready, e0, e1);
      end
      if (can && has) begin
        m_full = 1'b1; m_id = g; m_last = g;
        m_res  = alu_ref(ra[g], rb[g], rop[g]);
        p[g]   = 1'b0;
      end else if (m_full && rsp_ready) begin
        m_full = 1'b0;
      end
      tick();
    end
    idle_inputs();
  endtask

  initial begin
    reset = 1'b1;
    rsp_ready = 1'b0;
    idle_inputs();
    #1;
    test_reset();
    test_single_add();
    test_alternate();
    test_backpressure();
    test_opcodes();
    test_reset_midflight();
    test_stream();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
